// File: rtl/line_buffer_array.sv
// line_buffer_array: round-robin filled line buffers with a registered one-hot-selected display read port.
module line_buffer_array #(
    parameter int COLR_PXL_WIDTH = 12,
    parameter int TILE_WIDTH     = 4,
    parameter int WIDTH_PX       = 640,
    parameter int NUM_BUFFERS    = 2,
    parameter int TILE_PER_LINE  = WIDTH_PX / TILE_WIDTH,
    parameter int TILE_CTR_WIDTH = $clog2(TILE_PER_LINE),
    parameter int BUFF_ID_WIDTH  = (NUM_BUFFERS > 2) ? $clog2(NUM_BUFFERS) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_BUFFERS-1:0]    buff_fill_req_i,
    input  logic [NUM_BUFFERS-1:0]    buff_sel_i,
    input  logic [TILE_CTR_WIDTH-1:0] disp_pxl_id_i,
    input  logic [COLR_PXL_WIDTH-1:0] fill_data_i,
    input  logic                      fill_valid_i,
    output logic                      fill_ready_o,
    output logic [BUFF_ID_WIDTH-1:0]  fill_buff_id_o,
    output logic                      fill_busy_o,
    output logic [NUM_BUFFERS-1:0]    buff_fill_done_o,
    output logic [COLR_PXL_WIDTH-1:0] disp_pxl_o
);
    localparam logic [TILE_CTR_WIDTH-1:0] LAST = TILE_CTR_WIDTH'(TILE_PER_LINE - 1);
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
    state_t                      state, state_nx;
    logic [COLR_PXL_WIDTH-1:0]   mem [NUM_BUFFERS][TILE_PER_LINE];
    logic [BUFF_ID_WIDTH-1:0]    id, ptr, gnt_id, k, sel_idx;
    logic [TILE_CTR_WIDTH-1:0]   addr;
    logic [NUM_BUFFERS-1:0]      elig;
    logic                        gnt_ok, sel_ok, rd_ok, wr_en;
    assign elig    = buff_fill_req_i & ~buff_sel_i;
    assign wr_en   = (state == FILL) && fill_valid_i && !rst_i;
    assign sel_ok  = (buff_sel_i != '0) && ((buff_sel_i & (buff_sel_i - 1'b1)) == '0);
    assign rd_ok   = sel_ok && ({1'b0, disp_pxl_id_i} < (TILE_CTR_WIDTH + 1)'(TILE_PER_LINE));
    assign fill_ready_o     = state == FILL;
    assign fill_busy_o      = state != IDLE;
    assign fill_buff_id_o   = id;
    assign buff_fill_done_o = (state == DONE) ? (NUM_BUFFERS'(1) << id) : '0;
    // Scan from the highest rotated offset down so the one closest to ptr wins.
    always_comb begin
        gnt_ok = 1'b0;
        gnt_id = '0;
        k      = '0;
        for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
            k = BUFF_ID_WIDTH'((int'(ptr) + i) % NUM_BUFFERS);
            if (elig[k]) begin
                gnt_ok = 1'b1;
                gnt_id = k;
            end
        end
    end
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_BUFFERS; i++)
            if (buff_sel_i[i]) sel_idx = BUFF_ID_WIDTH'(i);
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = gnt_ok ? FILL : IDLE;
            FILL:    state_nx = (fill_valid_i && addr == LAST) ? DONE : FILL;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            ptr   <= '0;
            addr  <= '0;
            id    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && gnt_ok) begin
                id   <= gnt_id;
                addr <= '0;
            end
            if (wr_en && addr != LAST) addr <= addr + 1'b1;
            if (state == DONE) ptr <= (id == BUFF_ID_WIDTH'(NUM_BUFFERS - 1)) ? '0 : id + 1'b1;
        end
    end
    // Memory is never reset so an aborted fill keeps what was already written.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[id][addr] <= fill_data_i;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) disp_pxl_o <= '0;
        else       disp_pxl_o <= rd_ok ? mem[sel_idx][disp_pxl_id_i] : '0;
    end
endmodule

// File: doc/line_buffer_array.md
LINE_BUFFER_ARRAY -- requirements
Module: line_buffer_array

Interface
REQ-001 SHALL have parameter COLR_PXL_WIDTH, default 12, meaning bits per pixel colour word.
REQ-002 SHALL have parameter TILE_WIDTH, default 4, meaning pixels per tile.
REQ-003 SHALL have parameter WIDTH_PX, default 640, meaning visible line width in pixels.
REQ-004 SHALL have parameter NUM_BUFFERS, default 2, legal range 2..8, meaning number of line buffers.
REQ-005 SHALL derive TILE_PER_LINE = WIDTH_PX/TILE_WIDTH, TILE_CTR_WIDTH = $clog2(TILE_PER_LINE), BUFF_ID_WIDTH = max(1,$clog2(NUM_BUFFERS)).
REQ-006 SHALL have port clk_i  in  1  single clock, all logic on its rising edge.
REQ-007 SHALL have port rst_i  in  1  reset; synchronous, active-high.
REQ-008 SHALL have port buff_fill_req_i  in  NUM_BUFFERS  level fill request per buffer.
REQ-009 SHALL have port buff_sel_i  in  NUM_BUFFERS  one-hot display buffer select.
REQ-010 SHALL have port disp_pxl_id_i  in  TILE_CTR_WIDTH  display read address (tile index).
REQ-011 SHALL have port fill_data_i  in  COLR_PXL_WIDTH  fill write data.
REQ-012 SHALL have port fill_valid_i  in  1  fill data valid.
REQ-013 SHALL have port fill_ready_o  out  1  block accepts fill data.
REQ-014 SHALL have port fill_buff_id_o  out  BUFF_ID_WIDTH  index of buffer being filled.
REQ-015 SHALL have port fill_busy_o  out  1  fill in progress.
REQ-016 SHALL have port buff_fill_done_o  out  NUM_BUFFERS  one-cycle fill-complete pulse per buffer.
REQ-017 SHALL have port disp_pxl_o  out  COLR_PXL_WIDTH  registered display pixel.

Function
REQ-018 SHALL contain NUM_BUFFERS internal memories of TILE_PER_LINE x COLR_PXL_WIDTH, one write port (fill) and one registered read port (display).
REQ-019 SHALL implement FSM IDLE -> FILL -> DONE -> IDLE.
REQ-020 IDLE: SHALL grant one buffer with request high and not selected by buff_sel_i, round-robin starting from priority pointer; grant sets fill_buff_id_o, clears address counter to 0, enters FILL next cycle.
REQ-021 IDLE with no eligible request SHALL remain IDLE; fill_ready_o=0, fill_busy_o=0.
REQ-022 FILL: fill_ready_o=1, fill_busy_o=1; each cycle with fill_valid_i=1 SHALL write fill_data_i to buffer[fill_buff_id_o][addr] and increment addr.
REQ-023 FILL: fill_valid_i=0 SHALL stall with no write and no address change.
REQ-024 FILL: accepted beat at addr = TILE_PER_LINE-1 SHALL be the last write and enter DONE; address SHALL never exceed TILE_PER_LINE-1.
REQ-025 DONE: SHALL assert buff_fill_done_o[fill_buff_id_o] for exactly one cycle, fill_ready_o=0, fill_busy_o=1, set priority pointer to (fill_buff_id_o+1) mod NUM_BUFFERS, return to IDLE.
REQ-026 Request deassertion during FILL SHALL be ignored; fill runs to completion.
REQ-027 buff_sel_i switching to the buffer being filled mid-fill SHALL NOT abort the fill; reads return current contents.
REQ-028 disp_pxl_o SHALL equal buffer[sel][disp_pxl_id_i] one cycle after address/select presented.
REQ-029 disp_pxl_o SHALL be 0 next cycle when buff_sel_i is not one-hot or disp_pxl_id_i >= TILE_PER_LINE.
REQ-030 Simultaneous write and read of same buffer/address SHALL return old data (read-first).

Reset
REQ-031 rst_i=1 at a clock edge SHALL force IDLE, priority pointer 0, addr 0, fill_ready_o=0, fill_busy_o=0, fill_buff_id_o=0, buff_fill_done_o=0, disp_pxl_o=0.
REQ-032 Reset mid-FILL SHALL abandon the fill without a done pulse; memory contents SHALL NOT be cleared.
REQ-033 First grant after reset SHALL be evaluated in the first cycle with rst_i=0.

Verification (NUM_BUFFERS=2, TILE_PER_LINE=160)
REQ-034 Req[0]=1, sel=2'b10, valid held 1, data=index -> 160 writes, done[0] pulse once at cycle after beat 159; then sel=2'b01, id=37 -> disp_pxl_o=37 one cycle later.
REQ-035 Req=2'b11, sel=2'b00 -> buffer 0 filled first, then buffer 1; repeat -> pointer alternates 1,0 order.
REQ-036 Req[1]=1, sel=2'b10 -> no grant, fill_busy_o=0; sel changes to 2'b01 -> grant buffer 1 next cycle.
REQ-037 Valid toggled every other cycle during fill -> exactly 160 writes, done after 160th accepted beat, data intact.
REQ-038 rst_i=1 at beat 80 -> outputs zero, no done pulse; re-request -> fill restarts at address 0.
REQ-039 sel=2'b11 or disp_pxl_id_i=160 -> disp_pxl_o=0.
